// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and address field helpers for the
// direct-mapped write-back data cache.
package cache_pkg;

  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int ADDR_W      = 8;
  localparam int INDEX_W     = $clog2(NUM_BLOCKS);
  localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W      = 8 * BLOCK_BYTES;
  localparam int MADDR_W     = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } cache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  function automatic logic [7:0] line_byte(input logic [LINE_W-1:0] line,
                                           input logic [OFFSET_W-1:0] off);
    return line[8*off +: 8];
  endfunction

endpackage

// File: rtl/dcache_storage.sv
// Data/tag/valid/dirty arrays of the data cache. Only valid and dirty are
// reset; data and tag contents are meaningless until a line is installed.
module dcache_storage
  import cache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [INDEX_W-1:0]  rd_idx_i,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [LINE_W-1:0]   rd_line_o,
  input  logic                wr_en_i,
  input  logic [INDEX_W-1:0]  wr_idx_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [7:0]          wr_byte_i,
  input  logic                inst_en_i,
  input  logic [INDEX_W-1:0]  inst_idx_i,
  input  logic [TAG_W-1:0]    inst_tag_i,
  input  logic [LINE_W-1:0]   inst_line_i
);

  logic [7:0]            data_q  [NUM_BLOCKS][BLOCK_BYTES];
  logic [TAG_W-1:0]      tag_q   [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;

  always_comb begin
    rd_tag_o   = tag_q[rd_idx_i];
    rd_valid_o = valid_q[rd_idx_i];
    rd_dirty_o = dirty_q[rd_idx_i];
    rd_line_o  = '0;
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      rd_line_o[8*b +: 8] = data_q[rd_idx_i][b];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inst_en_i) begin
      valid_q[inst_idx_i] <= 1'b1;
      dirty_q[inst_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (inst_en_i) begin
      tag_q[inst_idx_i] <= inst_tag_i;
      for (int b = 0; b < BLOCK_BYTES; b++) begin
        data_q[inst_idx_i][b] <= inst_line_i[8*b +: 8];
      end
    end else if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_byte_i;
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back data cache controller: hit compare, miss FSM
// (IDLE/WRITEBACK/FETCH/UPDATE), request latch and CPU/memory output muxing.
module data_cache_ctrl
  import cache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [7:0]         WRITEDATA,
  output logic [7:0]         READDATA,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [MADDR_W-1:0] MEM_ADDRESS,
  output logic [LINE_W-1:0]  MEM_WRITEDATA,
  input  logic [LINE_W-1:0]  MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output cache_state_e       DBG_STATE
);

  cache_state_e       state_q, state_d;
  logic [INDEX_W-1:0] req_idx_q;
  logic [TAG_W-1:0]   req_tag_q;
  logic [LINE_W-1:0]  fill_q;
  logic [7:0]         readdata_q;

  logic [INDEX_W-1:0] rd_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid, rd_dirty, hit;
  logic [LINE_W-1:0]  rd_line;
  logic [7:0]         hit_byte;

  logic               busy, mem_rd, mem_wr, read_hit, byte_wr, install, latch_req, capture;
  logic [MADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_wdata;

  // Outside IDLE the arrays are looked up with the latched miss index.
  assign rd_idx   = (state_q == IDLE) ? addr_index(ADDRESS) : req_idx_q;
  assign hit      = rd_valid && (rd_tag == addr_tag(ADDRESS));
  assign hit_byte = line_byte(rd_line, addr_offset(ADDRESS));

  dcache_storage u_storage (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .rd_idx_i    (rd_idx),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_line_o   (rd_line),
    .wr_en_i     (byte_wr),
    .wr_idx_i    (addr_index(ADDRESS)),
    .wr_off_i    (addr_offset(ADDRESS)),
    .wr_byte_i   (WRITEDATA),
    .inst_en_i   (install),
    .inst_idx_i  (req_idx_q),
    .inst_tag_i  (req_tag_q),
    .inst_line_i (fill_q)
  );

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    read_hit  = 1'b0;
    byte_wr   = 1'b0;
    install   = 1'b0;
    latch_req = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (READ || WRITE) begin
          if (hit) begin
            read_hit = READ;
            byte_wr  = !READ;
          end else begin
            busy      = 1'b1;
            latch_req = 1'b1;
            state_d   = (rd_valid && rd_dirty) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {rd_tag, req_idx_q};
        mem_wdata = rd_line;
        if (!MEM_BUSYWAIT) state_d = FETCH;
      end
      FETCH: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {req_tag_q, req_idx_q};
        if (!MEM_BUSYWAIT) begin
          capture = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busy    = 1'b1;
        install = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must silence the stall immediately even while a miss request is held.
  assign BUSYWAIT      = busy && !RESET;
  assign MEM_READ      = mem_rd;
  assign MEM_WRITE     = mem_wr;
  assign MEM_ADDRESS   = mem_addr;
  assign MEM_WRITEDATA = mem_wdata;
  assign READDATA      = read_hit ? hit_byte : readdata_q;
  assign DBG_STATE     = state_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      req_idx_q  <= '0;
      req_tag_q  <= '0;
      fill_q     <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        req_idx_q <= addr_index(ADDRESS);
        req_tag_q <= addr_tag(ADDRESS);
      end
      if (capture)  fill_q     <= MEM_READDATA;
      if (read_hit) readdata_q <= hit_byte;
    end
  end

endmodule
